text_console_ctrl: RTL and testbench
====================================

// Module: text_console_ctrl
// PURPOSE
//  Parametrised text-mode console controller for the GPU: a CPU command stream
//  (opcode word, then parameter word) edits a COLS x ROWS character RAM and a
//  cursor. The character RAM is dual-ported: the VGA text renderer reads it
//  independently through the disp_* port.
//  New vs. previous text path:
//  - valid/ready handshake on the CPU side;
//  - full-screen clear, including a clear after reset;
//  - hardware scroll;
//  - cursor clamping.
// PARAMETERS
//  COLS      40  characters per row
//  ROWS      25  rows per screen
//  CHAR_W    8   bits per stored character
//  ADDR_W    12  cell address width; must satisfy 2**ADDR_W >= COLS*ROWS
//  SCROLL_EN 1   1: overflow past the last row scrolls; 0: cursor wraps to (0,0)
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  clr        in   1       asynchronous reset, active-low
//  cpu_valid  in   1       cpu_data holds a word for this block
//  cpu_data   in   16      opcode word or parameter word
//  cpu_ready  out  1       block accepts a word this cycle
//  busy       out  1       clear or scroll in progress
//  cur_x      out  ADDR_W  cursor column, 0..COLS-1
//  cur_y      out  ADDR_W  cursor row, 0..ROWS-1
//  disp_addr  in   ADDR_W  renderer read address (y*COLS+x)
//  disp_char  out  CHAR_W  character at disp_addr, registered
// BEHAVIOUR
//  Reset (clr=0, async)
//   - cur_x=0, cur_y=0, disp_char=0, cpu_ready=0, busy=1.
//   - State forced to CLEAR, scan index to 0; any command or scroll in flight is aborted.
//  Transfer
//   - A word transfers when cpu_valid && cpu_ready on a clk edge.
//   - cpu_ready=1 only in IDLE and PARAM.
//  FSM
//   - IDLE: transfer -> latch opcode -> PARAM.
//   - PARAM: transfer -> latch parameter -> EXEC.
//   - EXEC (1 cycle): act on the opcode -> IDLE, CLEAR or SCROLL.
//   - CLEAR: writes 0 to cell i each cycle, i = 0..COLS*ROWS-1, for exactly COLS*ROWS
//     cycles, then -> IDLE with cursor (0,0).
//   - SCROLL: cell[i] <= cell[i+COLS] for i < (ROWS-1)*COLS, then the last row is
//     zeroed. One cell per cycle; pipelined read adds 1 cycle, so SCROLL lasts
//     COLS*ROWS+1 cycles. Then -> IDLE.
//   - busy=1 exactly in CLEAR and SCROLL.
//  Opcodes (16-bit; any other opcode: parameter consumed, no effect)
//   - 0xC0: param==0 behaves as C5; param!=0 is a no-op (reserved for graphics mode).
//   - 0xC1 PUTC: cell[cur] <= param[CHAR_W-1:0], then cursor advances.
//     - x<COLS-1: x+1.
//     - Otherwise x=0 and y+1, or, if y==ROWS-1:
//       - SCROLL_EN=1: y stays ROWS-1, go to SCROLL;
//       - SCROLL_EN=0: cursor (0,0).
//   - 0xC2 BKSP:
//     - At (0,0): no-op.
//     - x>0: x-1.
//     - x==0: (COLS-1, y-1).
//     - In both moving cases, the new cell <= 0.
//   - 0xC3 SETY: y <= min(param, ROWS-1). 0xC4 SETX: x <= min(param, COLS-1).
//   - 0xC5 CLS: go to CLEAR.
//   - 0xC6 NEWLINE: x=0; y+1. At y==ROWS-1: SCROLL if SCROLL_EN, else cursor (0,0).
//  Arithmetic
//   - Cell address = y*COLS+x, computed in ADDR_W bits; no overflow by parameter rule.
//   - Parameter compares are unsigned, on the full 16 bits.
//  Display port
//   - disp_char = cell[disp_addr] one clk after disp_addr.
//   - disp_addr >= COLS*ROWS returns 0.
//   - Reads during CLEAR or SCROLL return current RAM contents; tearing is allowed.
//   - Write-through is not required: a read of a cell written the same cycle returns old data.
// TESTING
//  1 Release clr -> cpu_ready=0 and busy=1 for 1000 cycles (40x25) -> cpu_ready=1;
//    every disp_addr 0..999 reads 0.
//  2 Send C1/0x41 three times -> cells 0..2 = 'A', cur=(3,0); disp_addr=1 -> disp_char=0x41 next cycle.
//  3 C3/30 then C4/99 -> cur=(39,24), clamped; C1/0x5A with SCROLL_EN=1 -> cell 999 written, then
//    SCROLL for 1001 cycles; old cell 999 moves to 959, cells 960..999 = 0, cur=(0,24).
//  4 Same as 3 with SCROLL_EN=0 -> no scroll, cur=(0,0), cell 999 = 0x5A.
//  5 BKSP at (0,0) -> no change; at (0,1) -> cur=(39,0), cell 39 = 0; C0/1 and opcode 0x1234 -> no effect.
//  6 Pull clr low mid-SCROLL and with cpu_valid held high -> cur=(0,0) at once; a full CLEAR runs;
//    no word is accepted until it finishes.

Source files
------------

// File: rtl/text_console_ctrl.sv
// Text-mode console controller: a CPU opcode/parameter stream edits a COLS x ROWS
// character RAM and a cursor, while the renderer reads the RAM through its own port.
module text_console_ctrl #(
  parameter int COLS      = 40,
  parameter int ROWS      = 25,
  parameter int CHAR_W    = 8,
  parameter int ADDR_W    = 12,
  parameter bit SCROLL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_valid,
  input  logic [15:0]       cpu_data,
  output logic              cpu_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_x,
  output logic [ADDR_W-1:0] cur_y,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [CHAR_W-1:0] disp_char
);

  localparam int NCELLS = COLS * ROWS;
  localparam int RAM_AW = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int IDX_W  = ADDR_W + 1;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NCELLS - 1);
  localparam logic [IDX_W-1:0]  IDX_END  = IDX_W'(NCELLS);
  localparam logic [IDX_W-1:0]  IDX_MOVE = IDX_W'((ROWS - 1) * COLS);
  localparam logic [IDX_W-1:0]  IDX_COLS = IDX_W'(COLS);
  localparam logic [ADDR_W-1:0] X_MAX    = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] Y_MAX    = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [15:0]       X_MAX16  = 16'(COLS - 1);
  localparam logic [15:0]       Y_MAX16  = 16'(ROWS - 1);

  localparam logic [15:0] OP_GFX  = 16'h00C0;
  localparam logic [15:0] OP_PUTC = 16'h00C1;
  localparam logic [15:0] OP_BKSP = 16'h00C2;
  localparam logic [15:0] OP_SETY = 16'h00C3;
  localparam logic [15:0] OP_SETX = 16'h00C4;
  localparam logic [15:0] OP_CLS  = 16'h00C5;
  localparam logic [15:0] OP_NL   = 16'h00C6;

  typedef enum logic [2:0] {S_IDLE, S_PARAM, S_EXEC, S_CLEAR, S_SCROLL} state_t;

  state_t             state_q;
  logic [15:0]        opcode_q, param_q;
  logic [ADDR_W-1:0]  cur_x_q, cur_y_q;
  logic [IDX_W-1:0]   idx_q;
  logic               ready_q, busy_q;
  logic [CHAR_W-1:0]  disp_char_q;
  logic [CHAR_W-1:0]  scroll_rd_q;
  logic [CHAR_W-1:0]  ram_q [NCELLS];

  logic [ADDR_W-1:0]  cur_addr, bksp_x, bksp_y, bksp_addr;
  logic               at_origin, wrap_row, go_clear, go_scroll;
  logic [IDX_W-1:0]   idx_prev, scroll_src;
  logic               we;
  logic [ADDR_W-1:0]  waddr;
  logic [CHAR_W-1:0]  wdata;

  assign cur_addr   = cur_y_q * COLS_A + cur_x_q;
  assign at_origin  = (cur_x_q == '0) && (cur_y_q == '0);
  assign wrap_row   = (cur_y_q == Y_MAX);
  assign bksp_x     = (cur_x_q == '0) ? X_MAX : cur_x_q - ADDR_W'(1);
  assign bksp_y     = (cur_x_q == '0) ? cur_y_q - ADDR_W'(1) : cur_y_q;
  assign bksp_addr  = bksp_y * COLS_A + bksp_x;
  assign idx_prev   = idx_q - IDX_W'(1);
  assign scroll_src = idx_q + IDX_COLS;
  assign go_clear   = (opcode_q == OP_CLS) || ((opcode_q == OP_GFX) && (param_q == '0));
  assign go_scroll  = SCROLL_EN && wrap_row &&
                      (((opcode_q == OP_PUTC) && !(cur_x_q < X_MAX)) || (opcode_q == OP_NL));

  // Scroll writes lag reads by one cycle, so cell idx-1 receives the word fetched last cycle.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    case (state_q)
      S_EXEC: begin
        if (opcode_q == OP_PUTC) begin
          we    = 1'b1;
          waddr = cur_addr;
          wdata = param_q[CHAR_W-1:0];
        end else if ((opcode_q == OP_BKSP) && !at_origin) begin
          we    = 1'b1;
          waddr = bksp_addr;
        end
      end
      S_CLEAR: begin
        we    = 1'b1;
        waddr = idx_q[ADDR_W-1:0];
      end
      S_SCROLL: begin
        if (idx_q != '0) begin
          we    = 1'b1;
          waddr = idx_prev[ADDR_W-1:0];
          wdata = (idx_prev < IDX_MOVE) ? scroll_rd_q : '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < IDX_END)) ram_q[waddr[RAM_AW-1:0]] <= wdata;
    if (scroll_src < IDX_END) scroll_rd_q <= ram_q[scroll_src[RAM_AW-1:0]];
    else                      scroll_rd_q <= '0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_CLEAR;
      idx_q       <= '0;
      opcode_q    <= '0;
      param_q     <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      disp_char_q <= '0;
    end else begin
      if ({1'b0, disp_addr} < IDX_END) disp_char_q <= ram_q[disp_addr[RAM_AW-1:0]];
      else                             disp_char_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (cpu_valid) begin
            opcode_q <= cpu_data;
            state_q  <= S_PARAM;
          end
        end
        S_PARAM: begin
          if (cpu_valid) begin
            param_q <= cpu_data;
            state_q <= S_EXEC;
            ready_q <= 1'b0;
          end
        end
        S_EXEC: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          idx_q   <= '0;
          if (go_clear || go_scroll) begin
            state_q <= go_clear ? S_CLEAR : S_SCROLL;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
          case (opcode_q)
            OP_PUTC: begin
              if (cur_x_q < X_MAX) begin
                cur_x_q <= cur_x_q + ADDR_W'(1);
              end else begin
                cur_x_q <= '0;
                if (!wrap_row)      cur_y_q <= cur_y_q + ADDR_W'(1);
                else if (!SCROLL_EN) cur_y_q <= '0;
              end
            end
            OP_NL: begin
              cur_x_q <= '0;
              if (!wrap_row)      cur_y_q <= cur_y_q + ADDR_W'(1);
              else if (!SCROLL_EN) cur_y_q <= '0;
            end
            OP_BKSP: begin
              if (!at_origin) begin
                cur_x_q <= bksp_x;
                cur_y_q <= bksp_y;
              end
            end
            OP_SETY: cur_y_q <= (param_q > Y_MAX16) ? Y_MAX : ADDR_W'(param_q);
            OP_SETX: cur_x_q <= (param_q > X_MAX16) ? X_MAX : ADDR_W'(param_q);
            default: ;
          endcase
        end
        S_CLEAR: begin
          if (idx_q == IDX_LAST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_SCROLL: begin
          if (idx_q == IDX_END) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ready = ready_q;
  assign busy      = busy_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign disp_char = disp_char_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: a scrolling and a wrapping instance share the
// stimulus; expected cursor/handshake states and display reads are queued and checked by a monitor.
module tb_text_console_ctrl;

  localparam int COLS   = 40;
  localparam int ROWS   = 25;
  localparam int CHAR_W = 8;
  localparam int ADDR_W = 12;
  localparam int NCELLS = COLS * ROWS;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              cpuValid = 1'b0;
  logic [15:0]       cpuData = '0;
  logic [ADDR_W-1:0] dispAddr = '0;

  logic              readyS, busyS, readyW, busyW;
  logic [ADDR_W-1:0] curXS, curYS, curXW, curYW;
  logic [CHAR_W-1:0] charS, charW;

  logic              observeWrap = 1'b0;
  logic              obsReady, obsBusy;
  logic [ADDR_W-1:0] obsX, obsY;
  logic [CHAR_W-1:0] obsChar;

  logic rdReq = 1'b0;
  logic rdReqD = 1'b0;
  logic stProbe = 1'b0;

  typedef struct { string name; int exp; } charExp_t;
  typedef struct { string name; int x; int y; int ready; int busy; } statExp_t;

  charExp_t charQ[$];
  statExp_t statQ[$];
  charExp_t ce;
  statExp_t se;

  int checks = 0;
  int failures = 0;
  int n;

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .ADDR_W(ADDR_W), .SCROLL_EN(1'b1)) dutScroll (
    .clk(clk), .clr(clr), .cpu_valid(cpuValid), .cpu_data(cpuData), .cpu_ready(readyS), .busy(busyS),
    .cur_x(curXS), .cur_y(curYS), .disp_addr(dispAddr), .disp_char(charS)
  );

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .ADDR_W(ADDR_W), .SCROLL_EN(1'b0)) dutWrap (
    .clk(clk), .clr(clr), .cpu_valid(cpuValid), .cpu_data(cpuData), .cpu_ready(readyW), .busy(busyW),
    .cur_x(curXW), .cur_y(curYW), .disp_addr(dispAddr), .disp_char(charW)
  );

  assign obsReady = observeWrap ? readyW : readyS;
  assign obsBusy  = observeWrap ? busyW  : busyS;
  assign obsX     = observeWrap ? curXW  : curXS;
  assign obsY     = observeWrap ? curYW  : curYS;
  assign obsChar  = observeWrap ? charW  : charS;

  always #5 clk = ~clk;

  // A display read request becomes a registered character one edge later.
  always @(posedge clk) rdReqD <= rdReq;

  function automatic void checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: pops queued expectations whenever the DUT presents a read result or a status probe.
  always @(negedge clk) begin
    if (rdReqD) begin
      if (charQ.size() == 0) checkOutput("char_queue_underflow", 1, 0);
      else begin
        ce = charQ.pop_front();
        checkOutput(ce.name, int'(obsChar), ce.exp);
      end
    end
    if (stProbe) begin
      if (statQ.size() == 0) checkOutput("status_queue_underflow", 1, 0);
      else begin
        se = statQ.pop_front();
        checkOutput({se.name, ".x"}, int'(obsX), se.x);
        checkOutput({se.name, ".y"}, int'(obsY), se.y);
        checkOutput({se.name, ".ready"}, int'(obsReady), se.ready);
        checkOutput({se.name, ".busy"}, int'(obsBusy), se.busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rdReq = 1'b0;
    stProbe = 1'b0;
  endtask

  task automatic expectChar(input string tag, input int addr, input int exp);
    charExp_t e;
    e.name = $sformatf("%s_cell%0d", tag, addr);
    e.exp = exp;
    charQ.push_back(e);
    dispAddr = ADDR_W'(addr);
    rdReq = 1'b1;
    tick();
  endtask

  task automatic expectStatus(input string tag, input int x, input int y, input int rdy, input int bsy);
    statExp_t e;
    e.name = tag; e.x = x; e.y = y; e.ready = rdy; e.busy = bsy;
    statQ.push_back(e);
    stProbe = 1'b1;
    tick();
  endtask

  task automatic sendWord(input logic [15:0] w);
    int k = 0;
    cpuValid = 1'b1;
    cpuData = w;
    while (!obsReady && k < 5000) begin
      tick();
      k++;
    end
    if (!obsReady) checkOutput("ready_timeout", 0, 1);
    tick();
    cpuValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] op, input logic [15:0] prm);
    sendWord(op);
    sendWord(prm);
    tick();
  endtask

  task automatic waitWhileBusy(output int cnt);
    cnt = 0;
    while (obsBusy && cnt < 5000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic waitForReady(output int cnt);
    cnt = 0;
    while (!obsReady && cnt < 5000) begin
      tick();
      cnt++;
    end
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state and the clear that follows release
    tick();
    tick();
    expectStatus("reset", 0, 0, 0, 1);
    expectChar("reset", 5, 0);
    clr = 1'b1;
    waitForReady(n);
    checkOutput("boot_clear_len", n, 1000);
    expectStatus("boot_done", 0, 0, 1, 0);
    for (int a = 0; a < NCELLS; a++) expectChar("boot", a, 0);
    expectChar("oob", 1000, 0);

    // Three PUTCs
    for (int i = 0; i < 3; i++) applyStimulus(16'h00C1, 16'h0041);
    expectStatus("putc3", 3, 0, 1, 0);
    expectChar("putc", 0, 65);
    expectChar("putc", 1, 65);
    expectChar("putc", 2, 65);
    expectChar("putc", 3, 0);

    // Clamping and scroll at the last cell
    applyStimulus(16'h00C3, 16'd1);
    applyStimulus(16'h00C4, 16'd0);
    applyStimulus(16'h00C1, 16'h0042);
    expectStatus("row1_putc", 1, 1, 1, 0);
    applyStimulus(16'h00C3, 16'd30);
    applyStimulus(16'h00C4, 16'd99);
    expectStatus("clamp", 39, 24, 1, 0);
    applyStimulus(16'h00C4, 16'h1005);
    expectStatus("clamp_wide", 39, 24, 1, 0);
    applyStimulus(16'h00C1, 16'h005A);
    waitWhileBusy(n);
    checkOutput("scroll_len", n, 1001);
    expectStatus("scroll_done", 0, 24, 1, 0);
    expectChar("scroll", 0, 66);
    expectChar("scroll", 1, 0);
    expectChar("scroll", 40, 0);
    expectChar("scroll", 958, 0);
    expectChar("scroll", 959, 90);
    expectChar("scroll", 960, 0);
    expectChar("scroll", 999, 0);
    tick();

    // Same sequence on the wrapping instance
    observeWrap = 1'b1;
    expectStatus("wrap_cur", 0, 0, 1, 0);
    expectChar("wrap", 999, 90);
    expectChar("wrap", 959, 0);
    expectChar("wrap", 40, 66);
    expectChar("wrap", 0, 65);
    tick();
    observeWrap = 1'b0;

    // Backspace, reserved and unknown opcodes, newline
    applyStimulus(16'h00C3, 16'd0);
    applyStimulus(16'h00C4, 16'd0);
    applyStimulus(16'h00C2, 16'd0);
    expectStatus("bksp_origin", 0, 0, 1, 0);
    expectChar("bksp_origin", 0, 66);
    applyStimulus(16'h00C4, 16'd39);
    applyStimulus(16'h00C1, 16'h0043);
    expectStatus("putc_wrap", 0, 1, 1, 0);
    expectChar("putc_wrap", 39, 67);
    expectChar("oob_alias", 1063, 0);
    applyStimulus(16'h00C2, 16'd0);
    expectStatus("bksp_row", 39, 0, 1, 0);
    expectChar("bksp_row", 39, 0);
    applyStimulus(16'h00C2, 16'd0);
    expectStatus("bksp_col", 38, 0, 1, 0);
    applyStimulus(16'h00C0, 16'd1);
    expectStatus("gfx_noop", 38, 0, 1, 0);
    expectChar("gfx_noop", 0, 66);
    applyStimulus(16'h1234, 16'd7);
    expectStatus("unknown_op", 38, 0, 1, 0);
    applyStimulus(16'h00C6, 16'd0);
    expectStatus("newline", 0, 1, 1, 0);

    // C0 with zero parameter clears the screen
    applyStimulus(16'h00C0, 16'd0);
    waitWhileBusy(n);
    checkOutput("cls_len", n, 1000);
    expectStatus("cls_done", 0, 0, 1, 0);
    expectChar("cls", 0, 0);

    // Reset in the middle of a scroll with a word pending
    applyStimulus(16'h00C3, 16'd5);
    applyStimulus(16'h00C4, 16'd10);
    applyStimulus(16'h00C1, 16'h0045);
    expectChar("pre_abort", 210, 69);
    applyStimulus(16'h00C3, 16'd24);
    applyStimulus(16'h00C6, 16'd0);
    for (int i = 0; i < 100; i++) tick();
    cpuValid = 1'b1;
    cpuData = 16'h00C1;
    clr = 1'b0;
    expectStatus("abort", 0, 0, 0, 1);
    clr = 1'b1;
    waitForReady(n);
    checkOutput("abort_clear_len", n, 1000);
    tick();
    cpuData = 16'h0055;
    tick();
    cpuValid = 1'b0;
    tick();
    expectStatus("post_abort", 1, 0, 1, 0);
    expectChar("post_abort", 0, 85);
    expectChar("post_abort", 1, 0);
    expectChar("post_abort", 170, 0);
    expectChar("post_abort", 210, 0);
    expectChar("post_abort", 999, 0);

    tick();
    tick();
    checkOutput("char_queue_drained", charQ.size(), 0);
    checkOutput("status_queue_drained", statQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
